fb_write_sched: RTL
===================

Name: fb_write_sched

Overview:
Owns the single write port of the 1-bpp display framebuffer RAM (32-bit words, 15-bit word address, 640x480 = 9600 words). Shares that port between Avalon host pixel writes and a built-in fill engine. The fill engine clears or pattern-fills a word range, optionally deferred to the start of vertical blanking. Sits between the Avalon slave interface and the framebuffer RAM, alongside the VGA scan-out logic.

Parameters:
ADDR_W, 15, framebuffer word-address width
DATA_W, 32, framebuffer word width (32 pixels per word)
FB_WORDS, 9600, number of valid framebuffer words; addresses >= FB_WORDS are invalid

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  synchronous, active-high reset
chipselect  in  1  Avalon slave select
write  in  1  Avalon write strobe
read  in  1  Avalon read strobe
address  in  16  [15]=0: framebuffer word address[14:0]; [15]=1: register index address[1:0]
writedata  in  32  Avalon write data
readdata  out  32  Avalon read data, valid 1 cycle after read
vblank  in  1  high while vcount >= 480 (vertical blanking)
fb_wren  out  1  framebuffer RAM write enable
fb_wraddress  out  15  framebuffer RAM write address
fb_data  out  32  framebuffer RAM write data

Behaviour:
- Interface decision: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values: fb_wren=0, fb_wraddress=0, fb_data=0, readdata=0. All registers are 0. State=IDLE. The done flag is 0.
- Registers (address[15]=1):
  - 0 FILL_BASE[14:0]
  - 1 FILL_COUNT[14:0]
  - 2 FILL_DATA[31:0]
  - 3 CTRL, write-only: bit0 start, bit1 wait_vblank, bit2 abort
- Reads of any register index return STATUS: {29'b0, done, pending, busy}.
  - busy = (state==FILL).
  - pending = (state==WAIT_VB).
  - done is sticky; set on fill completion, cleared by start.
  - readdata is updated 1 cycle after chipselect&read.
- Host framebuffer write: chipselect & write & address[15]==0 & address[14:0] < FB_WORDS.
  - Next cycle: fb_wren=1, fb_wraddress=address[14:0], fb_data=writedata.
  - If address[14:0] >= FB_WORDS, the write is dropped (no fb_wren).
  - Latency is exactly 1 cycle and the host never stalls (no waitrequest).
- All fb_* outputs are registered. fb_wren is 0 on any cycle with no write.
- Start in IDLE (CTRL write with bit0=1, bit2=0):
  - Latch ptr=FILL_BASE, remain=min(FILL_COUNT, FB_WORDS), clear done.
  - remain==0: set done, stay IDLE.
  - Otherwise go to WAIT_VB if bit1, else FILL.
- Start while WAIT_VB or FILL: ignored. done is not cleared.
- FILL_* writes while busy or pending update the programmed registers only. The active operation uses the copies latched at start.
- FSM:
  - IDLE: waits for start, as above.
  - WAIT_VB: moves to FILL on the cycle vblank rises (vblank=1 while the previous sample was 0). An already-high vblank at start does not trigger; the fill waits for the next frame. abort -> IDLE.
  - FILL: on each cycle with no host framebuffer write, issue fb_wren=1, fb_wraddress=ptr, fb_data=latched FILL_DATA. Then ptr = (ptr==FB_WORDS-1) ? 0 : ptr+1, and remain -= 1. Issuing the write with remain==1 -> IDLE, done=1. abort -> IDLE, done stays 0, and no write issues that cycle.
- Arbitration: a valid host framebuffer write in the same cycle wins. The fill stalls that cycle; ptr and remain hold.
- abort and start in the same CTRL write: abort wins. Abort in IDLE: no effect.
- FILL_BASE >= FB_WORDS at start: ptr is latched as FILL_BASE mod FB_WORDS.
- Fill throughput: 1 word/cycle without host traffic. A full-screen fill takes 9600 cycles, which fits within one vblank (45 lines x 1600 = 72000 cycles).
- Reset mid-fill: fill terminated immediately, no further fb_wren, done=0.

Decomposition:
- Package fb_pkg: FB_WORDS, ADDR_W and DATA_W constants; register index localparams (REG_BASE=0, REG_COUNT=1, REG_DATA=2, REG_CTRL=3); CTRL/STATUS bit positions; state enum fill_state_t {IDLE, WAIT_VB, FILL}.
- One sub-module, fb_fill_engine, is natural. It contains the FSM, ptr/remain counters and vblank edge detector, and exposes a one-cycle-per-word request with a grant input.
- The top level holds the register file, address decode, arbiter and output registers.

Test Plan:
- Host write to address 16'h0005 with data 32'hDEADBEEF -> next cycle fb_wren=1, fb_wraddress=5, fb_data=DEADBEEF; write to 16'h2580 (9600) -> no fb_wren.
- BASE=100, COUNT=4, DATA=32'hFFFFFFFF, start with wait_vblank=0 -> fb_wren on 4 consecutive cycles at addresses 100..103; STATUS reads busy then 3'b100 (done).
- BASE=9598, COUNT=4 -> writes at 9598, 9599, 0, 1; COUNT=20000 -> exactly 9600 writes, then done.
- Start with wait_vblank=1 while vblank=0 -> STATUS pending=1, no writes; vblank rises -> first fill write one cycle later.
- During a fill, a host write to address 7 is issued mid-run -> that cycle writes address 7; fill resumes, addresses contiguous, total fill writes = COUNT.
- Abort issued 2 cycles into a COUNT=10 fill -> fewer than 10 writes, STATUS=0 (done=0); reset asserted mid-fill -> fb_wren=0 from the next cycle, STATUS=0.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared constants, register map and fill-engine state type for the
// framebuffer write scheduler.
package fb_pkg;

  localparam int ADDR_W   = 15;
  localparam int DATA_W   = 32;
  localparam int FB_WORDS = 9600;

  localparam logic [ADDR_W-1:0] FB_WORDS_A = ADDR_W'(FB_WORDS);
  localparam logic [ADDR_W-1:0] FB_LAST_A  = ADDR_W'(FB_WORDS - 1);

  localparam logic [1:0] REG_BASE  = 2'd0;
  localparam logic [1:0] REG_COUNT = 2'd1;
  localparam logic [1:0] REG_DATA  = 2'd2;
  localparam logic [1:0] REG_CTRL  = 2'd3;

  localparam int CTRL_START   = 0;
  localparam int CTRL_WAIT_VB = 1;
  localparam int CTRL_ABORT   = 2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_PENDING = 1;
  localparam int STAT_DONE    = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VB = 2'd1,
    FILL    = 2'd2
  } fill_state_t;

  // Any 15-bit value is below 4*FB_WORDS, so three conditional subtractions
  // reduce it modulo FB_WORDS without a divider.
  function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    r = a;
    for (int i = 0; i < 3; i++) begin
      if (r >= FB_WORDS_A) r = r - FB_WORDS_A;
    end
    return r;
  endfunction

endpackage

// File: rtl/fb_write_sched_if.sv
// Avalon-MM slave signals of the framebuffer write scheduler.
interface fb_write_sched_if;
  import fb_pkg::*;

  logic              chipselect;
  logic              write;
  logic              read;
  logic [15:0]       address;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;

  modport master (
    output chipselect, write, read, address, writedata,
    input  readdata
  );

  modport slave (
    input  chipselect, write, read, address, writedata,
    output readdata
  );

endinterface

// File: rtl/fb_fill_engine.sv
// Fill engine: FSM, word pointer/remaining counters and vblank edge detect.
// Requests one framebuffer word per cycle; advances only when granted.
module fb_fill_engine
  import fb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_wait_vb,
  input  logic              i_abort,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [ADDR_W-1:0] i_count,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_vblank,
  input  logic              i_grant,
  output logic              o_req,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data,
  output logic              o_busy,
  output logic              o_pending,
  output logic              o_done
);

  fill_state_t       r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] r_remain;
  logic [DATA_W-1:0] r_data;
  logic              r_done;
  logic              r_vblank_d;

  logic [ADDR_W-1:0] w_count_clamped;
  logic              w_vb_rise;

  assign w_count_clamped = (i_count > FB_WORDS_A) ? FB_WORDS_A : i_count;
  assign w_vb_rise       = i_vblank & ~r_vblank_d;

  // abort takes precedence, so no write is requested in the abort cycle.
  assign o_req     = (r_state == FILL) & ~i_abort;
  assign o_addr    = r_ptr;
  assign o_data    = r_data;
  assign o_busy    = (r_state == FILL);
  assign o_pending = (r_state == WAIT_VB);
  assign o_done    = r_done;

  always_ff @(posedge clk) begin
    // NOTE: synchronous reset lives inside the clocked block; every state
    // register gets an explicit value so reset mid-fill stops writes at once.
    if (reset) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_remain   <= '0;
      r_data     <= '0;
      r_done     <= 1'b0;
      r_vblank_d <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register sees the
      // pre-edge value of its neighbours regardless of statement order.
      r_vblank_d <= i_vblank;
      case (r_state)
        IDLE: begin
          if (i_start && !i_abort) begin
            r_ptr    <= wrap_addr(i_base);
            r_remain <= w_count_clamped;
            r_data   <= i_data;
            r_done   <= (w_count_clamped == '0);
            if (w_count_clamped != '0)
              r_state <= i_wait_vb ? WAIT_VB : FILL;
          end
        end
        WAIT_VB: begin
          if (i_abort)        r_state <= IDLE;
          else if (w_vb_rise) r_state <= FILL;
        end
        FILL: begin
          if (i_abort) begin
            r_state <= IDLE;
          end else if (i_grant) begin
            r_ptr    <= (r_ptr == FB_LAST_A) ? '0 : r_ptr + 1'b1;
            r_remain <= r_remain - 1'b1;
            if (r_remain == ADDR_W'(1)) begin
              r_state <= IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/fb_write_sched.sv
// Framebuffer write-port owner: Avalon register file and decode, host/fill
// arbitration (host wins) and registered RAM write outputs.
module fb_write_sched
  import fb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  fb_write_sched_if.slave   bus,
  input  logic              vblank,
  output logic              fb_wren,
  output logic [ADDR_W-1:0] fb_wraddress,
  output logic [DATA_W-1:0] fb_data
);

  logic [ADDR_W-1:0] r_fill_base;
  logic [ADDR_W-1:0] r_fill_count;
  logic [DATA_W-1:0] r_fill_data;
  logic [DATA_W-1:0] r_readdata;
  logic              r_fb_wren;
  logic [ADDR_W-1:0] r_fb_wraddress;
  logic [DATA_W-1:0] r_fb_data;

  logic              w_host_wr;
  logic              w_reg_wr;
  logic              w_start;
  logic              w_wait_vb;
  logic              w_abort;
  logic              w_fill_req;
  logic [ADDR_W-1:0] w_fill_addr;
  logic [DATA_W-1:0] w_fill_data;
  logic              w_busy;
  logic              w_pending;
  logic              w_done;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through it leaves a signal unassigned and no latch is inferred.
    w_host_wr = 1'b0;
    w_reg_wr  = 1'b0;
    w_start   = 1'b0;
    w_wait_vb = 1'b0;
    w_abort   = 1'b0;
    if (bus.chipselect && bus.write) begin
      if (bus.address[15]) begin
        w_reg_wr = 1'b1;
        if (bus.address[1:0] == REG_CTRL) begin
          w_start   = bus.writedata[CTRL_START];
          w_wait_vb = bus.writedata[CTRL_WAIT_VB];
          w_abort   = bus.writedata[CTRL_ABORT];
        end
      end else begin
        w_host_wr = (bus.address[ADDR_W-1:0] < FB_WORDS_A);
      end
    end
  end

  fb_fill_engine u_fill (
    .clk       (clk),
    .reset     (reset),
    .i_start   (w_start),
    .i_wait_vb (w_wait_vb),
    .i_abort   (w_abort),
    .i_base    (r_fill_base),
    .i_count   (r_fill_count),
    .i_data    (r_fill_data),
    .i_vblank  (vblank),
    .i_grant   (~w_host_wr),
    .o_req     (w_fill_req),
    .o_addr    (w_fill_addr),
    .o_data    (w_fill_data),
    .o_busy    (w_busy),
    .o_pending (w_pending),
    .o_done    (w_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fill_base    <= '0;
      r_fill_count   <= '0;
      r_fill_data    <= '0;
      r_readdata     <= '0;
      r_fb_wren      <= 1'b0;
      r_fb_wraddress <= '0;
      r_fb_data      <= '0;
    end else begin
      if (w_reg_wr) begin
        case (bus.address[1:0])
          REG_BASE:  r_fill_base  <= bus.writedata[ADDR_W-1:0];
          REG_COUNT: r_fill_count <= bus.writedata[ADDR_W-1:0];
          REG_DATA:  r_fill_data  <= bus.writedata;
          default:   ;
        endcase
      end

      if (bus.chipselect && bus.read)
        r_readdata <= {{(DATA_W-3){1'b0}}, w_done, w_pending, w_busy};

      // Host write owns the port this cycle; the engine holds its counters.
      r_fb_wren <= w_host_wr | w_fill_req;
      if (w_host_wr) begin
        r_fb_wraddress <= bus.address[ADDR_W-1:0];
        r_fb_data      <= bus.writedata;
      end else if (w_fill_req) begin
        r_fb_wraddress <= w_fill_addr;
        r_fb_data      <= w_fill_data;
      end
    end
  end

  assign bus.readdata = r_readdata;
  assign fb_wren      = r_fb_wren;
  assign fb_wraddress = r_fb_wraddress;
  assign fb_data      = r_fb_data;

endmodule
